// File: rtl/trace_pkg.sv
// Commit-trace record layout, store-size encodings and store-data masking.
package trace_pkg;

    localparam int unsigned TR_XLEN    = 32;
    localparam int unsigned TR_RADDR_W = 7;
    localparam int unsigned TR_SEQ_W   = 32;

    localparam logic [2:0] MEM_B = 3'b001;
    localparam logic [2:0] MEM_H = 3'b010;
    localparam logic [2:0] MEM_W = 3'b100;

    typedef struct packed {
        logic [TR_XLEN-1:0]    pc;
        logic [TR_RADDR_W-1:0] rd_addr;
        logic [TR_XLEN-1:0]    rd_wdata;
        logic [2:0]            mem_wen;
        logic [TR_XLEN-1:0]    mem_waddr;
        logic [TR_XLEN-1:0]    mem_wdata;
        logic [TR_XLEN-1:0]    mem_raddr;
        logic                  stale;
        logic [TR_SEQ_W-1:0]   seq;
    } trace_rec_t;

    // Narrowest size bit wins; the result is zero-extended store data.
    function automatic logic [TR_XLEN-1:0] mask_wdata(input logic [2:0] wen,
                                                      input logic [TR_XLEN-1:0] data);
        if ((wen & MEM_B) != 3'b000) begin
            mask_wdata = TR_XLEN'(data[7:0]);
        end else if ((wen & MEM_H) != 3'b000) begin
            mask_wdata = TR_XLEN'(data[15:0]);
        end else if ((wen & MEM_W) != 3'b000) begin
            mask_wdata = data;
        end else begin
            mask_wdata = '0;
        end
    endfunction

endpackage

// File: rtl/trace_pend_table.sv
// Per-rd table of slots awaiting late writeback data; arbitrates writeback
// ports and resolves retire/writeback collisions into fill and stale strobes.
module trace_pend_table #(
    parameter int unsigned NUM_WB  = 2,
    parameter int unsigned RADDR_W = 7,
    parameter int unsigned SLOT_W  = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       ret_pend,
    input  logic [RADDR_W-1:0]         ret_addr,
    input  logic [SLOT_W-1:0]          ret_slot,
    input  logic [NUM_WB-1:0]          wb_en,
    input  logic [NUM_WB*RADDR_W-1:0]  wb_addr,
    output logic [NUM_WB-1:0]          fill_en_c,
    output logic [NUM_WB*SLOT_W-1:0]   fill_slot_c,
    output logic                       stale_en_c,
    output logic [SLOT_W-1:0]          stale_slot_c
);

    localparam int unsigned TBL_N = 1 << RADDR_W;

    logic [TBL_N-1:0]   tbl_vld;
    logic [SLOT_W-1:0]  tbl_slot [TBL_N];
    logic [RADDR_W-1:0] wb_a     [NUM_WB];
    logic [NUM_WB-1:0]  dup_c;
    logic               wb_hits_ret_c;

    for (genvar g = 0; g < NUM_WB; g++) begin : g_wb_a
        assign wb_a[g] = wb_addr[g*RADDR_W +: RADDR_W];
    end

    // A port is shadowed when a lower-indexed enabled port names the same rd.
    always_comb begin
        dup_c = '0;
        for (int i = 1; i < NUM_WB; i++) begin
            for (int j = 0; j < i; j++) begin
                if (wb_en[j] && (wb_a[j] == wb_a[i])) begin
                    dup_c[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fill_en_c     = '0;
        fill_slot_c   = '0;
        wb_hits_ret_c = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            fill_slot_c[i*SLOT_W +: SLOT_W] = tbl_slot[wb_a[i]];
            if (wb_en[i] && (wb_a[i][4:0] != 5'd0) && tbl_vld[wb_a[i]] && !dup_c[i]) begin
                fill_en_c[i] = 1'b1;
                if (wb_a[i] == ret_addr) begin
                    wb_hits_ret_c = 1'b1;
                end
            end
        end
        stale_en_c   = ret_pend && tbl_vld[ret_addr] && !wb_hits_ret_c;
        stale_slot_c = tbl_slot[ret_addr];
    end

    // Fills retire their entry first so a same-cycle pending retire re-arms it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tbl_vld <= '0;
        end else begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (fill_en_c[i]) begin
                    tbl_vld[wb_a[i]] <= 1'b0;
                end
            end
            if (ret_pend) begin
                tbl_vld[ret_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ret_pend) begin
            tbl_slot[ret_addr] <= ret_slot;
        end
    end

endmodule

// File: rtl/trace_commit_buf.sv
// In-order commit-trace record buffer: captures retired rd writes and stores,
// waits for late rd writeback data, and streams completed records out in order.
module trace_commit_buf
    import trace_pkg::*;
#(
    parameter int unsigned XLEN    = TR_XLEN,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned NUM_WB  = 2,
    parameter int unsigned RADDR_W = TR_RADDR_W
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          ret_vld,
    input  logic [XLEN-1:0]               ret_pc,
    input  logic                          ret_rd_en,
    input  logic [RADDR_W-1:0]            ret_rd_addr,
    input  logic [XLEN-1:0]               ret_rd_wdata,
    input  logic                          ret_rd_pend,
    input  logic [2:0]                    ret_mem_wen,
    input  logic [XLEN-1:0]               ret_mem_waddr,
    input  logic [XLEN-1:0]               ret_mem_wdata,
    input  logic [2:0]                    ret_mem_ren,
    input  logic [XLEN-1:0]               ret_mem_raddr,
    input  logic [NUM_WB-1:0]             wb_en,
    input  logic [NUM_WB*RADDR_W-1:0]     wb_addr,
    input  logic [NUM_WB*XLEN-1:0]        wb_data,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output trace_rec_t                    out_rec,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned SLOT_W = $clog2(DEPTH);
    localparam int unsigned OCC_W  = SLOT_W + 1;

    trace_rec_t              slot_q [DEPTH];
    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0]        pend_q;
    logic [SLOT_W-1:0]       head_q;
    logic [SLOT_W-1:0]       tail_q;
    logic [TR_SEQ_W-1:0]     seq_q;

    logic                    vrd_c;
    logic                    rec_req_c;
    logic                    pop_c;
    logic                    push_c;
    logic                    drop_c;
    logic                    ret_pend_c;
    trace_rec_t              new_rec_c;
    logic [NUM_WB-1:0]       fill_en_c;
    logic [NUM_WB*SLOT_W-1:0] fill_slot_c;
    logic                    stale_en_c;
    logic [SLOT_W-1:0]       stale_slot_c;

    assign vrd_c      = ret_rd_en && (ret_rd_addr[4:0] != 5'd0);
    assign rec_req_c  = ret_vld && (vrd_c || (ret_mem_wen != 3'b000));
    assign pop_c      = out_vld && out_rdy;
    assign push_c     = rec_req_c && ((occupancy < OCC_W'(DEPTH)) || pop_c);
    assign drop_c     = rec_req_c && !push_c;
    assign ret_pend_c = push_c && vrd_c && ret_rd_pend;

    // Head is presented straight from slot state so a fresh record shows next cycle.
    assign out_vld = vld_q[head_q] && !pend_q[head_q];
    assign out_rec = out_vld ? slot_q[head_q] : '0;

    always_comb begin
        new_rec_c         = '0;
        new_rec_c.pc      = ret_pc;
        new_rec_c.mem_wen = ret_mem_wen;
        new_rec_c.seq     = seq_q;
        if (vrd_c) begin
            new_rec_c.rd_addr  = ret_rd_addr;
            new_rec_c.rd_wdata = ret_rd_pend ? '0 : ret_rd_wdata;
        end
        if (ret_mem_wen != 3'b000) begin
            new_rec_c.mem_waddr = ret_mem_waddr;
        end
        new_rec_c.mem_wdata = mask_wdata(ret_mem_wen, ret_mem_wdata);
        if (ret_mem_ren != 3'b000) begin
            new_rec_c.mem_raddr = ret_mem_raddr;
        end
    end

    trace_pend_table #(
        .NUM_WB  (NUM_WB),
        .RADDR_W (RADDR_W),
        .SLOT_W  (SLOT_W)
    ) u_pend (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .ret_pend     (ret_pend_c),
        .ret_addr     (ret_rd_addr),
        .ret_slot     (tail_q),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .fill_en_c    (fill_en_c),
        .fill_slot_c  (fill_slot_c),
        .stale_en_c   (stale_en_c),
        .stale_slot_c (stale_slot_c)
    );

    // Record payload; a slot's contents are meaningful only while vld_q is set.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            slot_q[tail_q] <= new_rec_c;
        end
        for (int i = 0; i < NUM_WB; i++) begin
            if (fill_en_c[i]) begin
                slot_q[fill_slot_c[i*SLOT_W +: SLOT_W]].rd_wdata <= wb_data[i*XLEN +: XLEN];
            end
        end
        if (stale_en_c) begin
            slot_q[stale_slot_c].stale <= 1'b1;
        end
    end

    // Slot status, pointers and counters; push follows pop so a full-buffer
    // push into the slot being vacated keeps it valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q     <= '0;
            pend_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            seq_q     <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (pop_c) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + SLOT_W'(1);
            end
            for (int i = 0; i < NUM_WB; i++) begin
                if (fill_en_c[i]) begin
                    pend_q[fill_slot_c[i*SLOT_W +: SLOT_W]] <= 1'b0;
                end
            end
            if (stale_en_c) begin
                pend_q[stale_slot_c] <= 1'b0;
            end
            if (push_c) begin
                vld_q[tail_q]  <= 1'b1;
                pend_q[tail_q] <= ret_pend_c;
                tail_q         <= tail_q + SLOT_W'(1);
                seq_q          <= seq_q + TR_SEQ_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/trace_commit_buf.md
# trace_commit_buf

Synthesizable commit-trace buffer that sits beside the core's retire stage and replaces file-based register-status logging with an in-order record stream. Each retired instruction that writes a non-zero rd or stores to memory becomes one record. Records whose rd data is not yet available at retire are held until a late writeback on one of `NUM_WB` ports fills them. Completed records leave in program order on a valid/ready port for an on-chip sink or a bench monitor.

## Interface
- `XLEN`, 32: data/address width.
- `DEPTH`, 16: record slots; power of two, ≥2.
- `NUM_WB`, 2: late-writeback ports.
- `RADDR_W`, 7: rd address width; pending table has 2**RADDR_W entries.
- `clk_i` in 1: clock; the block uses this single clock.
- `rstn_i` in 1: reset, asynchronous and active-low.
- `ret_vld` in 1: retire event this cycle.
- `ret_pc` in XLEN: retiring PC.
- `ret_rd_en` in 1: instruction writes rd.
- `ret_rd_addr` in RADDR_W: rd index.
- `ret_rd_wdata` in XLEN: rd data; ignored when `ret_rd_pend`.
- `ret_rd_pend` in 1: rd data arrives later via writeback.
- `ret_mem_wen` in 3: store size, one-hot; bit0 byte, bit1 half, bit2 word.
- `ret_mem_waddr`, `ret_mem_wdata` in XLEN: store address/data.
- `ret_mem_ren` in 3: load size, one-hot.
- `ret_mem_raddr` in XLEN: load address.
- `wb_en` in NUM_WB: late writeback valid per port.
- `wb_addr` in NUM_WB*RADDR_W: packed rd index per port.
- `wb_data` in NUM_WB*XLEN: packed data per port.
- `out_vld` out 1 / `out_rdy` in 1: record handshake.
- `out_rec` out `trace_rec_t`: pc, rd_addr, rd_wdata, mem_wen, mem_waddr, mem_wdata, mem_raddr, stale, seq (32b).
- `occupancy` out $clog2(DEPTH)+1: valid slots.
- `overflow` out 1: sticky, a record was dropped.
- `drop_cnt` out 16: dropped records, saturating.

## Operation
- vrd = `ret_rd_en` & (`ret_rd_addr[4:0]`≠0). A record is created when `ret_vld` & (vrd | `ret_mem_wen`≠0); otherwise the event is ignored.
- Field normalisation at capture:
  - rd_addr/rd_wdata are zero when !vrd.
  - mem_waddr is zero when wen=0; mem_raddr is zero when ren=0.
  - mem_wdata is masked by priority bit0 (zero-extended [7:0]) > bit1 ([15:0]) > bit2 (full), else 0.
- seq increments once per accepted record. Dropped records do not consume seq.
- Pending: vrd & `ret_rd_pend` marks the slot pending and sets table[rd] = {valid, slot index}.
- A new pending retire to an rd that already has a valid table entry:
  - the older slot is set stale and pending-cleared, keeping rd_wdata = 0;
  - the table then points to the new slot.
- Non-pending retires never modify the table.
- Late writeback: `wb_en[i]` & addr[4:0]≠0 & table[addr] valid → slot rd_wdata = data, slot pending cleared, table entry invalidated. A writeback with no matching table entry is ignored.
- Same rd on several ports in one cycle: the lowest index wins; the others are ignored.
- Writeback and pending retire to the same rd in one cycle: the writeback completes the older slot (not marked stale); the new slot becomes the table target.
- Head emits when the head slot is valid and not pending. Pop on `out_vld` & `out_rdy`.
- Full: a retire is accepted if occupancy<DEPTH or a pop occurs the same cycle. Otherwise it is dropped: `overflow` is set and `drop_cnt` increments, saturating at 0xFFFF.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: `out_vld` 0, `out_rec` 0, `occupancy` 0, `overflow` 0, `drop_cnt` 0, seq 0, pending table all invalid, pointers 0.
- Asynchronous reset mid-operation discards all slots and pending state immediately.
- Non-pending record retired at cycle N, buffer empty → `out_vld` high at N+1.
- Writeback at cycle M completes a pending head slot → `out_vld` high at M+1.
- `out_rec` is held stable while `out_vld` & !`out_rdy`.
- `out_vld` never deasserts without a pop.
- Occupancy updates in the cycle after the push/pop edge; a simultaneous push and pop leaves it unchanged.

## Structure
- `trace_pkg`:
  - `trace_rec_t` struct;
  - size constants `MEM_B`, `MEM_H`, `MEM_W`;
  - function `mask_wdata(wen, data)`.
- Sub-module `trace_pend_table`:
  - holds the 2**RADDR_W valid/slot-index table;
  - arbitrates writeback ports and resolves retire/writeback collisions;
  - returns fill/stale strobes with slot indices to the buffer.

## Test plan
- Retire pc=0x100, rd=10, data=0xDEADBEEF, `out_rdy`=1 → next cycle record {0x100, 10, 0xDEADBEEF}, seq=0.
- Store pc=0x104, wen=001, wdata=0x12345678, addr=0x2000 → mem_wdata=0x00000078, rd fields 0; rd=0 with rd_en=1 and no store → no record.
- Pending load rd=5 at pc=0x108, then non-pending rd=6 at 0x10C, writeback rd=5 data=0x55 three cycles later → no output until then; then 0x108 (data 0x55) followed by 0x10C, in order.
- Two pending retires to rd=7 with no writeback between, then writeback 0x77 → first record stale=1 with data 0, second record data 0x77.
- `out_rdy`=0, DEPTH+3 retires → occupancy=DEPTH, `overflow`=1, `drop_cnt`=3. A retire with a simultaneous pop when full is accepted.
- Both wb ports target pending rd=9 (0xA, 0xB) in one cycle → record data 0xA. Assert `rstn_i` mid-stream → all outputs 0 immediately.
